// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block: the duty scale and the
// measurement FSM state encoding.
package pwm_pkg;

  // Duty is reported on the same 10-step scale the PWM generator drives.
  localparam int DUTY_STEPS = 10;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_in_filter.sv
// Front end for the asynchronous PWM pin: a synchroniser chain, a stability
// filter that only follows the pin after FILT_LEN identical samples, and a
// rising-edge detector on the filtered level.
module pwm_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_pwm_in,
  output logic o_filt,
  output logic o_rise
);

  localparam int STABLE_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [STABLE_W-1:0]    r_stableCnt;
  logic                   r_filt;
  logic                   r_filtD;
  logic                   w_syncOut;

  assign w_syncOut = r_sync[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser flops to tame metastability.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm_in};
    end
  end

  // Flip the filtered level only once the synchronised level has disagreed with it for FILT_LEN consecutive samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_filt      <= 1'b0;
      r_filtD     <= 1'b0;
      r_stableCnt <= '0;
    end else begin
      r_filtD <= r_filt;
      if (w_syncOut != r_filt) begin
        if (r_stableCnt == STABLE_W'(FILT_LEN - 1)) begin
          r_filt      <= w_syncOut;
          r_stableCnt <= '0;
        end else begin
          r_stableCnt <= r_stableCnt + STABLE_W'(1);
        end
      end else begin
        r_stableCnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;
  assign o_rise = r_filt & ~r_filtD;

endmodule

// File: rtl/pwm_capture.sv
// Receive side of the PWM link. Measures period and high time between
// filtered rising edges, converts them to a rounded duty in tenths with a
// small restoring divider, and flags a stuck line when no edge arrives.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TIMEOUT     = 1000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_pwm_in,
  output logic             o_meas_valid,
  output logic [CNT_W-1:0] o_period_cnt,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic [3:0]       o_duty_tenths,
  output logic             o_stuck,
  output logic             o_overrun
);

  // The remainder holds 10*high + period/2, which needs four extra bits plus one for the rounding term.
  localparam int               REM_W     = CNT_W + 5;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       STEPS_Q   = 4'(DUTY_STEPS);

  pwm_cap_state_t r_state;
  pwm_cap_state_t w_stateNext;

  logic             w_filt;
  logic             w_rise;
  logic [CNT_W-1:0] r_perRun;
  logic [CNT_W-1:0] r_hiRun;
  logic [CNT_W-1:0] r_capPer;
  logic [CNT_W-1:0] r_capHi;
  logic [REM_W-1:0] r_rem;
  logic [3:0]       r_q;
  logic             r_measValid;
  logic [CNT_W-1:0] r_periodCnt;
  logic [CNT_W-1:0] r_highCnt;
  logic [3:0]       r_duty;
  logic             r_stuck;
  logic             r_overrun;

  logic [REM_W-1:0] w_perExt;
  logic [REM_W-1:0] w_remInit;
  logic             w_divStep;
  logic             w_timeoutHit;
  logic             w_capture;
  logic             w_step;
  logic             w_finish;
  logic             w_timeout;
  logic             w_overrun;

  pwm_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filter (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_pwm_in(i_pwm_in),
    .o_filt  (w_filt),
    .o_rise  (w_rise)
  );

  assign w_perExt     = REM_W'(r_capPer);
  assign w_remInit    = (REM_W'(r_hiRun) * REM_W'(DUTY_STEPS)) + REM_W'(r_perRun >> 1);
  assign w_divStep    = (r_rem >= w_perExt) && (r_q < STEPS_Q);
  assign w_timeoutHit = (r_perRun == TIMEOUT_C) && !r_stuck;

  // Run counters track the current period regardless of FSM state so a measurement can start on any edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_perRun <= '0;
      r_hiRun  <= '0;
    end else if (w_rise) begin
      r_perRun <= CNT_W'(1);
      r_hiRun  <= CNT_W'(1);
    end else begin
      if (r_perRun != TIMEOUT_C) begin
        r_perRun <= r_perRun + CNT_W'(1);
      end
      if (w_filt && (r_hiRun != TIMEOUT_C)) begin
        r_hiRun <= r_hiRun + CNT_W'(1);
      end
    end
  end

  // Measurement FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and per-cycle datapath strobes; a rise always beats a simultaneous timeout.
  always_comb begin
    w_stateNext = r_state;
    w_capture   = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    w_timeout   = 1'b0;
    w_overrun   = 1'b0;
    if (!i_en) begin
      w_stateNext = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            w_stateNext = MEASURE;
          end else if (w_timeoutHit) begin
            w_timeout = 1'b1;
          end
        end
        MEASURE: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_stateNext = DIVIDE;
          end else if (w_timeoutHit) begin
            w_timeout   = 1'b1;
            w_stateNext = IDLE;
          end
        end
        DIVIDE: begin
          w_overrun = w_rise;
          if (w_divStep) begin
            w_step = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_stateNext = MEASURE;
          end
        end
        default: begin
          w_stateNext = IDLE;
        end
      endcase
    end
  end

  // Capture, repeated-subtraction divide and result publication driven by the FSM strobes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_capPer    <= '0;
      r_capHi     <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_measValid <= 1'b0;
      r_periodCnt <= '0;
      r_highCnt   <= '0;
      r_duty      <= '0;
      r_stuck     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_measValid <= 1'b0;
      r_overrun   <= w_overrun;
      if (w_capture) begin
        r_capPer <= r_perRun;
        r_capHi  <= r_hiRun;
        r_rem    <= w_remInit;
        r_q      <= '0;
      end
      if (w_step) begin
        r_rem <= r_rem - w_perExt;
        r_q   <= r_q + 4'd1;
      end
      if (w_finish) begin
        r_periodCnt <= r_capPer;
        r_highCnt   <= r_capHi;
        r_duty      <= r_q;
        r_stuck     <= 1'b0;
        r_measValid <= 1'b1;
      end
      if (w_timeout) begin
        r_periodCnt <= '0;
        r_highCnt   <= '0;
        r_duty      <= w_filt ? STEPS_Q : 4'd0;
        r_stuck     <= 1'b1;
        r_measValid <= 1'b1;
      end
    end
  end

  assign o_meas_valid  = r_measValid;
  assign o_period_cnt  = r_periodCnt;
  assign o_high_cnt    = r_highCnt;
  assign o_duty_tenths = r_duty;
  assign o_stuck       = r_stuck;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven PWM waveforms with a
// scoreboard of expected reports, plus hand-written stuck, glitch, reset
// and enable sequences.
module tb_pwm_capture;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT_TB = 200;
  localparam int FULL_DUTY  = 10;

  typedef struct {
    int period;
    int high;
    int nPer;
    bit glitch;
    int expDuty;
  } vecRec_t;

  typedef struct {
    int per;
    int hi;
    int duty;
    int stuck;
  } expRec_t;

  logic             clk;
  logic             reset;
  logic             en;
  logic             pwmIn;
  logic             measValid;
  logic [CNT_W-1:0] periodCnt;
  logic [CNT_W-1:0] highCnt;
  logic [3:0]       dutyTenths;
  logic             stuck;
  logic             overrun;

  int      assertCount  = 0;
  int      failCount    = 0;
  int      overrunCount = 0;
  int      reportCount  = 0;
  expRec_t expQ[$];
  vecRec_t vecs[10];

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .FILT_LEN   (3),
    .TIMEOUT    (TIMEOUT_TB)
  ) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_en         (en),
    .i_pwm_in     (pwmIn),
    .o_meas_valid (measValid),
    .o_period_cnt (periodCnt),
    .o_high_cnt   (highCnt),
    .o_duty_tenths(dutyTenths),
    .o_stuck      (stuck),
    .o_overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveLevel(input logic level, input int n);
    pwmIn = level;
    repeat (n) @(negedge clk);
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (expQ.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending reports", expQ.size(), 0);
    expQ.delete();
  endtask

  // Drives nPer full periods plus one closing rise; a period closes when the next rise is driven.
  // When the divide outlasts the period (period <= duty+1) every other closing rise is dropped.
  task automatic applyStimulus(input vecRec_t v, input bit holdHigh);
    int expOv = 0;
    bit alt;
    alt = (v.period < v.expDuty + 2);
    overrunCount = 0;
    for (int k = 1; k <= v.nPer + 1; k++) begin
      if (k >= 2) begin
        if (!alt || (k % 2 == 0)) expQ.push_back('{v.period, v.high, v.expDuty, 0});
        else expOv++;
      end
      if (k == v.nPer + 1) begin
        if (holdHigh) begin
          expQ.push_back('{0, 0, FULL_DUTY, 1});
          driveLevel(1'b1, 1);
        end else begin
          driveLevel(1'b1, v.high);
          expQ.push_back('{0, 0, 0, 1});
          driveLevel(1'b0, 1);
        end
      end else begin
        driveLevel(1'b1, v.high);
        if (v.glitch) begin
          driveLevel(1'b0, 3);
          driveLevel(1'b1, 2);
          driveLevel(1'b0, v.period - v.high - 5);
        end else begin
          driveLevel(1'b0, v.period - v.high);
        end
      end
    end
    waitDrain(TIMEOUT_TB + 100);
    checkOutput("overrun count", overrunCount, expOv);
  endtask

  // Scoreboard: every report is compared against the oldest pending expectation.
  always @(negedge clk) begin
    if (overrun) overrunCount++;
    if (measValid) begin
      reportCount++;
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected report: period %0d high %0d duty %0d stuck %0d, expected none at %0t",
                 periodCnt, highCnt, dutyTenths, stuck, $time);
      end else begin
        expRec_t e;
        e = expQ.pop_front();
        checkOutput("period_cnt", int'(periodCnt), e.per);
        checkOutput("high_cnt", int'(highCnt), e.hi);
        checkOutput("duty_tenths", int'(dutyTenths), e.duty);
        checkOutput("stuck", int'(stuck), e.stuck);
      end
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int savedReports;
    vecs[0] = '{10, 5, 3, 1'b0, 5};
    vecs[1] = '{30, 3, 2, 1'b0, 1};
    vecs[2] = '{30, 27, 2, 1'b0, 9};
    vecs[3] = '{7, 3, 3, 1'b0, 4};
    vecs[4] = '{7, 4, 4, 1'b0, 6};
    vecs[5] = '{6, 3, 4, 1'b0, 5};
    vecs[6] = '{60, 57, 2, 1'b0, 10};
    vecs[7] = '{70, 3, 2, 1'b0, 0};
    vecs[8] = '{60, 3, 2, 1'b0, 1};
    vecs[9] = '{14, 5, 3, 1'b1, 4};

    reset = 1'b1;
    en    = 1'b1;
    pwmIn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset meas_valid", int'(measValid), 0);
    checkOutput("reset period_cnt", int'(periodCnt), 0);
    checkOutput("reset high_cnt", int'(highCnt), 0);
    checkOutput("reset duty", int'(dutyTenths), 0);
    checkOutput("reset stuck", int'(stuck), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      $display("[TB] row %0d: period %0d high %0d", i, vecs[i].period, vecs[i].high);
      applyStimulus(vecs[i], 1'b0);
    end

    $display("[TB] held-high stuck sequence");
    applyStimulus('{10, 5, 2, 1'b0, 5}, 1'b1);
    savedReports = reportCount;
    driveLevel(1'b0, 300);
    checkOutput("reports on level flip while stuck", reportCount, savedReports);
    checkOutput("stuck held", int'(stuck), 1);
    applyStimulus(vecs[0], 1'b0);

    $display("[TB] reset during divide");
    driveLevel(1'b1, 5);
    driveLevel(1'b0, 5);
    expQ.push_back('{10, 5, 5, 0});
    driveLevel(1'b1, 5);
    driveLevel(1'b0, 5);
    driveLevel(1'b1, 5);
    driveLevel(1'b0, 2);
    checkOutput("pre-reset period_cnt", int'(periodCnt), 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid reset meas_valid", int'(measValid), 0);
    checkOutput("mid reset period_cnt", int'(periodCnt), 0);
    checkOutput("mid reset high_cnt", int'(highCnt), 0);
    checkOutput("mid reset duty", int'(dutyTenths), 0);
    checkOutput("mid reset stuck", int'(stuck), 0);
    checkOutput("mid reset overrun", int'(overrun), 0);
    driveLevel(1'b0, 20);
    applyStimulus('{10, 5, 2, 1'b0, 5}, 1'b0);

    $display("[TB] enable dropped during measure");
    driveLevel(1'b1, 10);
    driveLevel(1'b0, 10);
    expQ.push_back('{20, 10, 5, 0});
    driveLevel(1'b1, 10);
    driveLevel(1'b0, 5);
    en = 1'b0;
    driveLevel(1'b0, 5);
    repeat (2) begin
      driveLevel(1'b1, 10);
      driveLevel(1'b0, 10);
    end
    checkOutput("hold period while disabled", int'(periodCnt), 20);
    driveLevel(1'b1, 10);
    driveLevel(1'b0, 5);
    en = 1'b1;
    driveLevel(1'b0, 5);
    driveLevel(1'b1, 10);
    driveLevel(1'b0, 10);
    expQ.push_back('{20, 10, 5, 0});
    driveLevel(1'b1, 10);
    expQ.push_back('{0, 0, 0, 1});
    driveLevel(1'b0, 1);
    waitDrain(TIMEOUT_TB + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
